// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush sequencing for the 5-stage core, with a saturating stall counter.
module hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             mem_halt,
  input  logic             ex_dREN,
  input  logic [REG_W-1:0] ex_wsel,
  input  logic [REG_W-1:0] dec_rs,
  input  logic [REG_W-1:0] dec_rt,
  input  logic             dec_uses_rt,
  input  logic             ex_branch_taken,
  output logic             pc_en,
  output logic             fd_en,
  output logic             fd_zero,
  output logic             de_en,
  output logic             de_zero,
  output logic             em_en,
  output logic             em_zero,
  output logic             mw_en,
  output logic             mw_zero,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {RUN, DWAIT, HALT} state_t;
  // Control word layout: {pc_en, fd_en, fd_zero, de_en, de_zero, em_en, em_zero, mw_en, mw_zero}
  localparam logic [8:0] ADV   = 9'b1_10_10_10_10;
  localparam logic [8:0] HALTC = 9'b0_11_11_11_10;
  localparam logic [8:0] DSTL  = 9'b0_00_00_00_11;
  localparam logic [8:0] BR    = 9'b1_11_11_10_10;
  localparam logic [8:0] LU    = 9'b0_00_11_10_10;
  localparam logic [8:0] MISS  = 9'b0_11_10_10_10;
  state_t state, state_n;
  logic dreq, luse;
  logic [8:0] ctl, res;
  assign dreq = mem_dREN | mem_dWEN;
  assign luse = ex_dREN & (ex_wsel != '0) & ((ex_wsel == dec_rs) | (dec_uses_rt & (ex_wsel == dec_rt)));
  assign res  = ex_branch_taken ? BR : luse ? LU : !ihit ? MISS : ADV;
  assign {pc_en, fd_en, fd_zero, de_en, de_zero, em_en, em_zero, mw_en, mw_zero} = ctl;
  always_comb begin
    state_n = state;
    ctl = '0;
    case (state)
      RUN: begin
        ctl = mem_halt ? HALTC : (dreq & !dhit) ? DSTL : res;
        state_n = mem_halt ? HALT : (dreq & !dhit) ? DWAIT : RUN;
      end
      DWAIT: begin
        ctl = dhit ? res : DSTL;
        state_n = dhit ? RUN : DWAIT;
      end
      default: ctl = '0;
    endcase
    if (!nRST) ctl = '0;
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= RUN;
      halted <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state <= state_n;
      halted <= (state_n == HALT);
      if (state != HALT && !pc_en && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage core. It drives the en/zero (stall/flush) pair of every inter-stage latch and the PC enable. It resolves data-memory waits, load-use hazards, taken control transfers from the exec stage, instruction-fetch misses and halt. It also keeps a saturating stall-cycle counter for performance debug.

Parameters:
REG_W, 5, register-address width of wsel/rs/rt
CNT_W, 32, width of stall_cnt

Ports:
CLK  input  1  system clock, rising edge
nRST  input  1  asynchronous active-low reset
ihit  input  1  instruction fetch for current PC completes this cycle
dhit  input  1  data access of the mem-stage instruction completes this cycle
mem_dREN  input  1  exec/mem latch holds a load
mem_dWEN  input  1  exec/mem latch holds a store
mem_halt  input  1  exec/mem latch holds halt
ex_dREN  input  1  decode/exec latch holds a load
ex_wsel  input  REG_W  destination register of the instruction in exec
dec_rs  input  REG_W  rs of the instruction in decode
dec_rt  input  REG_W  rt of the instruction in decode
dec_uses_rt  input  1  decode instruction reads rt
ex_branch_taken  input  1  exec resolved a taken branch/jump
pc_en  output  1  PC register loads next PC
fd_en, fd_zero  output  1 each  fetch/decode latch enable, flush
de_en, de_zero  output  1 each  decode/exec latch enable, flush
em_en, em_zero  output  1 each  exec/mem latch enable, flush
mw_en, mw_zero  output  1 each  mem/wb latch enable, flush
halted  output  1  core has halted
stall_cnt  output  CNT_W  cycles with pc_en=0 since reset, excluding HALT

Behaviour:
- The FSM state is registered. States: RUN, DWAIT, HALT.
- All en/zero outputs and pc_en are combinational from state and inputs. A flush means en=1 with zero=1.
- While nRST=0: every en/zero=0, pc_en=0, state=RUN, halted=0, stall_cnt=0.
- Define dreq = mem_dREN | mem_dWEN.
- Define luse = ex_dREN & (ex_wsel!=0) & (ex_wsel==dec_rs | (dec_uses_rt & ex_wsel==dec_rt)).
- "Advance" means all four en=1, zero=0, pc_en=1.
- RUN evaluates the following in priority order; the first match applies.
  1. mem_halt:
     - pc_en=0.
     - fd, de, em flush.
     - mw_en=1, mw_zero=0 (halt reaches WB).
     - Next state HALT.
  2. dreq & !dhit (data stall):
     - pc_en=0; fd_en=de_en=em_en=0.
     - mw flush (bubble into WB).
     - Next state DWAIT.
     - ex_branch_taken is ignored this cycle.
  3. ex_branch_taken:
     - pc_en=1 regardless of ihit; the in-flight fetch is discarded.
     - fd, de flush.
     - em_en=mw_en=1.
  4. luse:
     - pc_en=0, fd_en=0, de_en=0 (hold).
     - de_zero=1 with de_en=1 (bubble into exec).
     - em, mw advance.
  5. !ihit:
     - pc_en=0.
     - fd flush.
     - de, em, mw advance.
  6. Otherwise: advance.
- DWAIT:
  - While !dhit: same outputs as the data stall above.
  - On dhit: outputs equal RUN's evaluation of rules 3–6 on the same cycle; the branch is applied exactly once, here. Next state RUN.
  - mem_halt cannot coexist with dreq; no special case is required.
- HALT:
  - All en/zero=0, pc_en=0, halted=1.
  - Only reset exits HALT.
- halted is registered: it goes to 1 on the clock edge entering HALT.
- stall_cnt:
  - +1 on each rising edge where state!=HALT, nRST=1 and pc_en=0.
  - Saturates at 2^CNT_W-1; no wrap.
- Reset asserted mid-DWAIT or mid-stall returns the block to RUN immediately (asynchronous). Outputs are forced low while nRST=0.

Test Plan:
1. Reset release, ihit=1, no hazards for 10 cycles -> every cycle advances (pc_en=1, all en=1, all zero=0); stall_cnt=0; halted=0.
2. mem_dREN=1, dhit=0 for 3 cycles then dhit=1 -> 3 cycles with pc_en=0, fd/de/em_en=0, mw_en=1, mw_zero=1; state DWAIT after the first edge; on the 4th cycle all advance; stall_cnt=3.
3. ex_dREN=1, ex_wsel=8, dec_rs=8; ex_wsel=0 case; dec_uses_rt=1 with dec_rt=8 -> ex_wsel=8, dec_rs=8 gives pc_en=0, fd_en=0, de_en=1, de_zero=1, em/mw advance; the identical setup with ex_wsel=0 advances normally; dec_uses_rt=1 with dec_rt=8 stalls.
4. ex_branch_taken=1 with ihit=0 and luse=1 -> pc_en=1, fd_zero=1, de_zero=1 (branch beats load-use and fetch miss); the same branch raised during a 2-cycle data stall produces flushes only on the dhit cycle, exactly once.
5. mem_halt=1 -> that cycle mw_en=1, mw_zero=0, fd/de/em flushed, pc_en=0; next edge halted=1; all outputs stay 0 for 20 cycles; stall_cnt frozen.
6. nRST pulsed low during DWAIT and during HALT -> outputs drop to 0 asynchronously; after release state is RUN, halted=0, stall_cnt=0. Also preload stall_cnt near its maximum with CNT_W=4 -> the count holds at 15.
